// File: rtl/prover_shuffle_ctrl_pkg.sv
// prover_shuffle_ctrl_pkg: shared FSM state encoding, output bundle and round index width helper
package prover_shuffle_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESTART,
        WAIT_SH,
        PRESENT,
        ADVANCE,
        FINISH
    } state_e;

    typedef struct packed {
        logic sh_en;
        logic sh_restart;
        logic round_valid;
        logic busy;
        logic done;
        logic timeout;
    } ctrl_out_t;

    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/prover_timeout_ctr.sv
// prover_timeout_ctr: watchdog counting cycles while count is high, pulsing expired on the Limit-th cycle
module prover_timeout_ctr #(
    parameter int Limit = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CW = $clog2(Limit + 1);

    logic [CW-1:0] cnt_q;

    assign expired = count && (cnt_q == CW'(Limit - 1));

    // count held cycles; stop at the expiry value so the counter never wraps
    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt_q <= '0;
        else if (count && !expired)
            cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/prover_shuffle_ctrl.sv
// prover_shuffle_ctrl: sequences restart/enable/present/ack rounds of a shuffle datapath with a watchdog
module prover_shuffle_ctrl
    import prover_shuffle_ctrl_pkg::*;
#(
    parameter int nValBits      = 4,
    parameter int nParBits      = 1,
    parameter int TimeoutCycles = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         sh_ready_pulse,
    input  logic                         round_ack,
    output logic                         sh_en,
    output logic                         sh_restart,
    output logic                         round_valid,
    output logic [idx_w(nValBits)-1:0]   round_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout
);

    localparam int IW = idx_w(nValBits);
    localparam logic [IW-1:0] LastIdx = IW'(nValBits - 1);

    if (nValBits < 1 || nParBits < 1 || TimeoutCycles < 1) begin : g_bad_params
        $error("prover_shuffle_ctrl: nValBits, nParBits and TimeoutCycles must all be >= 1");
    end

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    ctrl_out_t       out_q, out_d;
    logic            timeout_d;
    logic            expired;

    // the watchdog is held clear outside WAIT_SH, so each entry starts from zero
    prover_timeout_ctr #(.Limit(TimeoutCycles)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != WAIT_SH),
        .count   (state_q == WAIT_SH),
        .expired (expired)
    );

    // state, round index and all outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    // next state: abort beats everything, a ready pulse beats watchdog expiry
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RESTART;
                        idx_d   = '0;
                    end
                end
                RESTART: state_d = WAIT_SH;
                WAIT_SH: begin
                    if (sh_ready_pulse) begin
                        state_d = PRESENT;
                    end else if (expired) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
                PRESENT: begin
                    if (round_ack) begin
                        state_d = (idx_q == LastIdx) ? FINISH : ADVANCE;
                        idx_d   = (idx_q == LastIdx) ? idx_q : idx_q + IW'(1);
                    end
                end
                ADVANCE: state_d = WAIT_SH;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // outputs decoded from the state being entered so they appear registered with it
    always_comb begin
        out_d             = '0;
        out_d.sh_en       = (state_d == RESTART) || (state_d == ADVANCE);
        out_d.sh_restart  = (state_d == RESTART);
        out_d.round_valid = (state_d == PRESENT);
        out_d.busy        = (state_d != IDLE);
        out_d.done        = (state_d == FINISH);
        out_d.timeout     = timeout_d;
    end

    assign sh_en       = out_q.sh_en;
    assign sh_restart  = out_q.sh_restart;
    assign round_valid = out_q.round_valid;
    assign busy        = out_q.busy;
    assign done        = out_q.done;
    assign timeout     = out_q.timeout;
    assign round_idx   = idx_q;

endmodule

// File: tb/tb_prover_shuffle_ctrl.sv
// tb_prover_shuffle_ctrl: randomized protocol runs checked against event counts and latencies from the round protocol
module tb_prover_shuffle_ctrl;
    import prover_shuffle_ctrl_pkg::*;

    localparam int NV = 4;
    localparam int TO = 16;
    localparam int IW = idx_w(NV);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic sh_ready_pulse = 1'b0, round_ack = 1'b0;
    logic sh_en, sh_restart, round_valid, busy, done, timeout;
    logic [IW-1:0] round_idx;

    int errors = 0, checks = 0;
    int n_en = 0, n_rs = 0, n_done = 0, n_to = 0;

    prover_shuffle_ctrl #(.nValBits(NV), .nParBits(1), .TimeoutCycles(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .sh_ready_pulse (sh_ready_pulse),
        .round_ack      (round_ack),
        .sh_en          (sh_en),
        .sh_restart     (sh_restart),
        .round_valid    (round_valid),
        .round_idx      (round_idx),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    // strobe tallies, sampled mid-cycle
    always @(negedge clk) begin
        if (sh_en === 1'b1) n_en++;
        if (sh_restart === 1'b1) n_rs++;
        if (done === 1'b1) n_done++;
        if (timeout === 1'b1) n_to++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_en = 0; n_rs = 0; n_done = 0; n_to = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; abort = 1;
        tick(); tick();
        checks++;
        if ({sh_en, sh_restart, round_valid, busy, done, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000000", {sh_en, sh_restart, round_valid, busy, done, timeout});
        end
        checks++;
        if (round_idx !== '0) begin
            errors++;
            $display("FAIL reset_round_idx got=%0d exp=0", round_idx);
        end
        rst = 0; start = 0; abort = 0;
        tick();
    endtask

    // one full run; rnd picks random delays, spam holds start high, spur injects ignored pulses/acks
    task automatic run_once(input bit rnd, input bit spam, input bit spur);
        bit held_ok;
        int d, a;
        held_ok = 1;
        clr_counts();
        start = 1;
        tick();
        start = spam;
        checks++;
        if (!(sh_restart === 1 && sh_en === 1 && busy === 1)) begin
            errors++;
            $display("FAIL start_latency got rs=%b en=%b busy=%b exp 1 1 1", sh_restart, sh_en, busy);
        end
        for (int r = 0; r < NV; r++) begin
            d = rnd ? int'($urandom_range(1, 6)) : 3;
            a = rnd ? int'($urandom_range(0, 4)) : 2;
            for (int k = 1; k <= d; k++) begin
                tick();
                if (round_valid !== 1'b0) held_ok = 0;
                round_ack = spur && (k < d);
            end
            sh_ready_pulse = 1;
            tick();
            sh_ready_pulse = 0;
            checks++;
            if (round_valid !== 1'b1 || round_idx !== IW'(r)) begin
                errors++;
                $display("FAIL round_present got valid=%b idx=%0d exp valid=1 idx=%0d", round_valid, round_idx, r);
            end
            for (int k = 0; k < a; k++) begin
                sh_ready_pulse = spur;
                tick();
                sh_ready_pulse = 0;
                if (round_valid !== 1'b1 || sh_en !== 1'b0) held_ok = 0;
            end
            round_ack = 1;
            tick();
            round_ack = 0;
            if (r == NV - 1) begin
                start = 0;
                checks++;
                if (done !== 1'b1 || round_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL run_done got done=%b valid=%b exp done=1 valid=0", done, round_valid);
                end
            end else begin
                checks++;
                if (sh_en !== 1'b1 || sh_restart !== 1'b0 || round_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL advance_latency round=%0d got en=%b rs=%b valid=%b exp 1 0 0", r, sh_en, sh_restart, round_valid);
                end
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL run_idle_after got busy=%b done=%b exp 0 0", busy, done);
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL round_valid_hold got=0 exp=1");
        end
        checks++;
        if (n_rs != 1 || n_en != NV || n_done != 1 || n_to != 0) begin
            errors++;
            $display("FAIL run_strobe_counts got rs=%0d en=%0d done=%0d to=%0d exp rs=1 en=%0d done=1 to=0", n_rs, n_en, n_done, n_to, NV);
        end
    endtask

    task automatic test_timeout();
        int i;
        clr_counts();
        start = 1; tick(); start = 0; tick();
        i = 0;
        while (timeout !== 1'b1 && i < 3 * TO) begin
            tick();
            i++;
        end
        checks++;
        if (i != TO) begin
            errors++;
            $display("FAIL timeout_latency got=%0d exp=%0d", i, TO);
        end
        checks++;
        if (busy !== 1'b0 || round_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle got busy=%b valid=%b exp 0 0", busy, round_valid);
        end
        tick();
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b0 || n_done != 0 || n_to != 1) begin
            errors++;
            $display("FAIL timeout_pulse got to=%b busy=%b n_done=%0d n_to=%0d exp 0 0 0 1", timeout, busy, n_done, n_to);
        end
    endtask

    task automatic test_pulse_on_expiry();
        clr_counts();
        start = 1; tick(); start = 0; tick();
        repeat (TO - 1) tick();
        sh_ready_pulse = 1;
        tick();
        sh_ready_pulse = 0;
        checks++;
        if (round_valid !== 1'b1 || timeout !== 1'b0 || round_idx !== '0) begin
            errors++;
            $display("FAIL pulse_beats_expiry got valid=%b to=%b idx=%0d exp 1 0 0", round_valid, timeout, round_idx);
        end
        abort = 1; tick(); abort = 0;
        tick();
        checks++;
        if (n_to != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL expiry_no_timeout got n_to=%0d busy=%b exp 0 0", n_to, busy);
        end
    endtask

    task automatic test_abort();
        clr_counts();
        start = 1; tick(); start = 0;
        for (int r = 0; r < 3; r++) begin
            repeat (2) tick();
            sh_ready_pulse = 1; tick(); sh_ready_pulse = 0;
            if (r < 2) begin
                round_ack = 1; tick(); round_ack = 0;
            end
        end
        checks++;
        if (round_valid !== 1'b1 || round_idx !== IW'(2)) begin
            errors++;
            $display("FAIL abort_setup got valid=%b idx=%0d exp 1 2", round_valid, round_idx);
        end
        abort = 1; tick(); abort = 0;
        checks++;
        if ({sh_en, sh_restart, round_valid, busy, done, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL abort_outputs got=%b exp=000000", {sh_en, sh_restart, round_valid, busy, done, timeout});
        end
        start = 1; tick(); start = 0;
        repeat (2) tick();
        sh_ready_pulse = 1; tick(); sh_ready_pulse = 0;
        checks++;
        if (round_valid !== 1'b1 || round_idx !== '0) begin
            errors++;
            $display("FAIL abort_restart_idx got valid=%b idx=%0d exp 1 0", round_valid, round_idx);
        end
        abort = 1; round_ack = 1; start = 1;
        tick();
        abort = 0; round_ack = 0; start = 0;
        checks++;
        if ({sh_en, sh_restart, round_valid, busy, done, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL abort_priority got=%b exp=000000", {sh_en, sh_restart, round_valid, busy, done, timeout});
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        clr_counts();
        start = 1; tick(); start = 0;
        repeat (2) tick();
        sh_ready_pulse = 1; tick(); sh_ready_pulse = 0;
        round_ack = 1; tick(); round_ack = 0;
        tick();
        rst = 1;
        tick();
        checks++;
        if ({sh_en, sh_restart, round_valid, busy, done, timeout} !== 6'b0 || round_idx !== '0) begin
            errors++;
            $display("FAIL midrun_reset got=%b idx=%0d exp=000000 idx=0", {sh_en, sh_restart, round_valid, busy, done, timeout}, round_idx);
        end
        tick();
        rst = 0;
        repeat (TO + 6) tick();
        checks++;
        if (n_done != 0 || n_to != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_quiet got n_done=%0d n_to=%0d busy=%b exp 0 0 0", n_done, n_to, busy);
        end
    endtask

    task automatic test_nominal();
        run_once(0, 0, 0);
    endtask

    task automatic test_start_spam();
        run_once(0, 1, 0);
    endtask

    task automatic test_spurious();
        run_once(0, 0, 1);
    endtask

    task automatic test_back_to_back();
        run_once(1, 0, 0);
        run_once(1, 1, 1);
    endtask

    task automatic test_random_runs();
        for (int i = 0; i < 8; i++) run_once(1, 1'($urandom % 2), 1'($urandom % 2));
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_start_spam();
        test_spurious();
        test_timeout();
        test_pulse_on_expiry();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        test_random_runs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
